// File: rtl/adc_spi_rd.sv
// Periodic 16-bit SPI (mode 0, MSB first) ADC reader.
// Captured sample is presented on data_o with a data_av_o strobe held AV_HOLD cycles.
module adc_spi_rd #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 200,
  parameter int unsigned AV_HOLD       = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        miso_i,
  output logic        sclk_o,
  output logic        cs_n_o,
  output logic [15:0] data_o,
  output logic        data_av_o,
  output logic        busy_o,
  output logic        missed_o
);

  localparam int unsigned TW = $clog2(SAMPLE_PERIOD);
  localparam logic [TW-1:0] TMR_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [3:0]    AV_LAST  = 4'(AV_HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_PRESENT  = 3'd4,
    ST_WAIT     = 3'd5
  } state_t;

  state_t        state_r, state_s;
  logic [7:0]    div_r, div_s;
  logic [4:0]    half_r, half_s;
  logic [3:0]    av_cnt_r, av_cnt_s;
  logic [TW-1:0] timer_r, timer_s;
  logic [15:0]   shift_r, shift_s;
  logic [15:0]   data_r, data_s;
  logic          miso_meta_r, miso_s_r;
  logic          tick_s, missed_s;
  logic          sclk_s, cs_n_s, av_s, busy_s;
  logic          sclk_r, cs_n_r, data_av_r, busy_r, missed_r;

  assign tick_s = en_i && (timer_r == TMR_LAST);

  // Two-flop synchronizer for the asynchronous ADC data line
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      miso_meta_r <= 1'b0;
      miso_s_r    <= 1'b0;
    end else begin
      miso_meta_r <= miso_i;
      miso_s_r    <= miso_meta_r;
    end
  end

  // Sample timer; an IDLE start realigns it so ticks land every P cycles after the start
  always_comb begin
    timer_s = timer_r;
    if (!en_i) begin
      timer_s = '0;
    end else if ((state_r == ST_IDLE) || (timer_r == TMR_LAST)) begin
      timer_s = '0;
    end else begin
      timer_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
    end
  end

  // Next-state logic: frame sequencing, bit shifting and overrun detection
  always_comb begin
    state_s  = state_r;
    div_s    = div_r;
    half_s   = half_r;
    av_cnt_s = av_cnt_r;
    shift_s  = shift_r;
    data_s   = data_r;
    missed_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en_i) begin
          state_s = ST_CS_SETUP;
          div_s   = 8'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CS_SETUP: begin
        missed_s = tick_s;
        if (div_r == DIV_LAST) begin
          state_s = ST_SHIFT;
          div_s   = 8'd0;
          half_s  = 5'd0;
        end else begin
          div_s = div_r + 8'd1;
        end
      end
      ST_SHIFT: begin
        missed_s = tick_s;
        if (div_r == DIV_LAST) begin
          div_s = 8'd0;
          // odd half-periods are SCLK high; capture at their last cycle
          if (half_r[0]) begin
            shift_s = {shift_r[14:0], miso_s_r};
          end else begin
            shift_s = shift_r;
          end
          if (half_r == 5'd31) begin
            state_s = ST_CS_HOLD;
          end else begin
            half_s = half_r + 5'd1;
          end
        end else begin
          div_s = div_r + 8'd1;
        end
      end
      ST_CS_HOLD: begin
        missed_s = tick_s;
        if (div_r == DIV_LAST) begin
          state_s  = ST_PRESENT;
          div_s    = 8'd0;
          av_cnt_s = 4'd0;
          data_s   = shift_r;
        end else begin
          div_s = div_r + 8'd1;
        end
      end
      ST_PRESENT: begin
        missed_s = tick_s;
        if (av_cnt_r == AV_LAST) begin
          state_s = ST_WAIT;
        end else begin
          av_cnt_s = av_cnt_r + 4'd1;
        end
      end
      ST_WAIT: begin
        if (!en_i) begin
          state_s = ST_IDLE;
        end else if (tick_s) begin
          state_s = ST_CS_SETUP;
          div_s   = 8'd0;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so every output is a flop
  always_comb begin
    sclk_s = (state_s == ST_SHIFT) && half_s[0];
    cs_n_s = !((state_s == ST_CS_SETUP) || (state_s == ST_SHIFT) || (state_s == ST_CS_HOLD));
    av_s   = (state_s == ST_PRESENT);
    busy_s = !cs_n_s || av_s;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      div_r     <= 8'd0;
      half_r    <= 5'd0;
      av_cnt_r  <= 4'd0;
      timer_r   <= '0;
      shift_r   <= 16'h0000;
      data_r    <= 16'h0000;
      sclk_r    <= 1'b0;
      cs_n_r    <= 1'b1;
      data_av_r <= 1'b0;
      busy_r    <= 1'b0;
      missed_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      div_r     <= div_s;
      half_r    <= half_s;
      av_cnt_r  <= av_cnt_s;
      timer_r   <= timer_s;
      shift_r   <= shift_s;
      data_r    <= data_s;
      sclk_r    <= sclk_s;
      cs_n_r    <= cs_n_s;
      data_av_r <= av_s;
      busy_r    <= busy_s;
      missed_r  <= missed_s;
    end
  end

  assign sclk_o    = sclk_r;
  assign cs_n_o    = cs_n_r;
  assign data_o    = data_r;
  assign data_av_o = data_av_r;
  assign busy_o    = busy_r;
  assign missed_o  = missed_r;

endmodule

// File: doc/adc_spi_rd.md
Name: adc_spi_rd

Overview:
Upstream acquisition stage. Periodically reads one 16-bit sample from an external SPI ADC (mode 0, MSB first) and presents it as data_o with a data_av_o strobe. data_o/data_av_o drive the data_i/data_av_ai inputs of the median/averaging pipeline top. The strobe is stretched so the downstream synchronizer always captures it.

Parameters:
CLK_DIV, 4, system clocks per SCLK half-period (D); legal range 3..255
SAMPLE_PERIOD, 200, system clocks between successive conversion starts (P)
AV_HOLD, 2, cycles data_av_o stays high per sample; legal range 1..15

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
en_i  in  1  enable periodic conversions
miso_i  in  1  ADC serial data, asynchronous to clk_i
sclk_o  out  1  SPI clock, idle low
cs_n_o  out  1  ADC chip select, active-low
data_o  out  16  last captured sample
data_av_o  out  1  new-sample strobe, high AV_HOLD cycles
busy_o  out  1  high from cs_n_o fall through end of the data_av_o pulse
missed_o  out  1  one-cycle pulse when a sample tick hits while busy

Behaviour:
- Reset (rst_i sampled high): sclk_o=0, cs_n_o=1, data_o=0, data_av_o=0, busy_o=0, missed_o=0. FSM to IDLE, timer and bit counter cleared. Applies mid-frame: frame aborted, no strobe, partial data discarded.
- miso_i passes through a 2-flop synchronizer (miso_s) before any use.
- Sample timer: counter 0..P-1. Cleared when en_i is low. In IDLE with en_i high, a start is issued that cycle and the timer restarts from 0. Subsequent starts occur every P cycles while en_i stays high.
- All outputs are registered. t0 = first cycle with cs_n_o=0, which is the cycle after the start.
- FSM states:
  - IDLE: waits for en_i.
  - CS_SETUP: t0..t0+D-1, sclk_o=0.
  - SHIFT: bit k = 0..15, MSB first. sclk_o low during cycles t0+D+2kD .. +D-1, then high for the next D cycles. miso_s is sampled in the last high cycle of each bit into a 16-bit shift register. The ADC changes data on the falling edge.
  - CS_HOLD: D cycles, sclk_o=0, cs_n_o=0.
  - PRESENT: at cycle t0+34D, cs_n_o=1, data_o loads the shift register, and data_av_o=1 for exactly AV_HOLD cycles.
  - WAIT: entered after PRESENT. Returns to CS_SETUP on the next tick if en_i is high, otherwise to IDLE.
- Frame length is 34D cycles. Exactly 16 sclk_o rising edges per frame.
- data_o holds its value between strobes and changes only in the PRESENT entry cycle.
- Overrun: requires P >= 34D+AV_HOLD+1. If a tick occurs in any state other than WAIT or IDLE, missed_o pulses for 1 cycle, the tick is dropped and the frame in progress continues. The next start is on the following tick.
- en_i deasserted mid-frame: the frame completes and data is delivered, then the FSM goes to IDLE with no further cs_n_o fall. Re-assertion in IDLE starts immediately.
- rst_i and a tick in the same cycle: reset wins.
- Internal miso_s-to-sample latency is 2 cycles. D>=3 guarantees the sampled value settled at least 1 cycle after the previous falling edge.

Test Plan:
- Defaults (D=4, P=200, AV_HOLD=2): ADC model returns 0xA5C3, en_i=1 → 16 sclk_o rising edges. cs_n_o low for 136 cycles. data_o=0xA5C3 with data_av_o high exactly 2 cycles at t0+136. busy_o falls at t0+138.
- Back-to-back samples 0x0001, 0xFFFF, 0x8000 → successive cs_n_o falls exactly 200 cycles apart; data_o matches each sample in order. missed_o is never asserted.
- rst_i pulsed for 1 cycle during bit 7 of a frame → next cycle: cs_n_o=1, sclk_o=0, data_o=0, no data_av_o pulse. With en_i high, a new frame starts with cs_n_o low 2 cycles after rst_i is released.
- en_i dropped at t0+50 → frame completes, data_o updated and strobed at t0+136. No cs_n_o fall in the following 400 cycles.
- Instance with P=100, D=4 → missed_o pulses once per dropped tick. Conversions occur every 200 cycles with correct data.
- Reset values check: hold rst_i high for 5 cycles with random miso_i → all outputs at their reset values throughout.
